// File: rtl/fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_hazard_scoreboard
//
// Forwarding and load-use hazard unit for the pipelined RISC-V core. It keeps
// a small destination-tag pipeline ({valid, rd, reg_write, mem_read} per stage)
// that advances in lockstep with the datapath.
//   stage 0                : instruction currently in EX
//   stage s (1..NUM_FWD_STAGES): instruction s stages after EX
// From these tags it derives per-port forward selects for the EX-stage source
// operands and a load-use stall for the ID stage. A flush that arrives while
// the pipeline is frozen is remembered and applied on the first moving cycle.
// Load-use stall cycles are counted in a saturating 32-bit counter.
//
// Ports:
//   clk_i              clock
//   reset_i            synchronous active-high reset
//   issue_valid_i      instruction leaving ID into EX this cycle
//   issue_rd_i         its destination register
//   issue_reg_write_i  it writes the register file
//   issue_mem_read_i   it is a load
//   pipe_stall_i       whole pipeline frozen (memory busy)
//   flush_i            kill the instruction entering EX
//   id_src_i           per-port source registers of the instruction in ID
//   id_src_used_i      per-port source valid, ID
//   ex_src_i           per-port source registers of the instruction in EX
//   ex_src_used_i      per-port source valid, EX
//   fwd_sel_o          per port: 0 = regfile, s = forward from stage s
//   load_use_stall_o   hold IF/ID and insert a bubble into EX
//   stall_count_o      saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
    parameter int NUM_PORTS      = 3,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_FWD_STAGE = 2,
    localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       issue_valid_i,
    input  logic [4:0]                 issue_rd_i,
    input  logic                       issue_reg_write_i,
    input  logic                       issue_mem_read_i,
    input  logic                       pipe_stall_i,
    input  logic                       flush_i,
    input  logic [NUM_PORTS*5-1:0]     id_src_i,
    input  logic [NUM_PORTS-1:0]       id_src_used_i,
    input  logic [NUM_PORTS*5-1:0]     ex_src_i,
    input  logic [NUM_PORTS-1:0]       ex_src_used_i,
    output logic [NUM_PORTS*SEL_W-1:0] fwd_sel_o,
    output logic                       load_use_stall_o,
    output logic [31:0]                stall_count_o
);

    // Tag pipeline state, one entry per stage 0..NUM_FWD_STAGES
    logic [NUM_FWD_STAGES:0]       stg_valid_q, stg_valid_d;
    logic [NUM_FWD_STAGES:0][4:0]  stg_rd_q,    stg_rd_d;
    logic [NUM_FWD_STAGES:0]       stg_rw_q,    stg_rw_d;
    logic [NUM_FWD_STAGES:0]       stg_mr_q,    stg_mr_d;
    logic                          pending_flush_q, pending_flush_d;
    logic [31:0]                   stall_count_q, stall_count_d;

    logic [NUM_PORTS*SEL_W-1:0]    fwd_sel_s;
    logic                          load_use_stall_s;

    // A stage produces register r when it is a live writer of r; x0 never matches.
    function automatic logic produces(input logic       valid,
                                      input logic       reg_write,
                                      input logic [4:0] rd,
                                      input logic [4:0] r);
        return valid && reg_write && (rd == r) && (r != 5'd0);
    endfunction

    // Forward select per EX port: scan far-to-near so the nearest producer wins.
    always_comb begin
        fwd_sel_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ex_src_used_i[p]) begin
                for (int s = NUM_FWD_STAGES; s >= 1; s--) begin
                    if (produces(stg_valid_q[s], stg_rw_q[s], stg_rd_q[s],
                                 ex_src_i[p*5 +: 5])) begin
                        fwd_sel_s[p*SEL_W +: SEL_W] = SEL_W'(s);
                    end else begin
                        fwd_sel_s[p*SEL_W +: SEL_W] = fwd_sel_s[p*SEL_W +: SEL_W];
                    end
                end
            end else begin
                fwd_sel_s[p*SEL_W +: SEL_W] = {SEL_W{1'b0}};
            end
        end
    end

    // Load-use detection: an ID source matches a load that will not yet have
    // reached a load-forwarding stage when the consumer is in EX (stage s+1).
    always_comb begin
        load_use_stall_s = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int s = 0; s <= NUM_FWD_STAGES; s++) begin
                if ((s + 1 < LOAD_FWD_STAGE) && id_src_used_i[p] && stg_mr_q[s] &&
                    produces(stg_valid_q[s], stg_rw_q[s], stg_rd_q[s],
                             id_src_i[p*5 +: 5])) begin
                    load_use_stall_s = 1'b1;
                end else begin
                    load_use_stall_s = load_use_stall_s;
                end
            end
        end
    end

    // Next-state: freeze on pipe_stall (remembering any flush), else advance.
    always_comb begin
        stg_valid_d     = stg_valid_q;
        stg_rd_d        = stg_rd_q;
        stg_rw_d        = stg_rw_q;
        stg_mr_d        = stg_mr_q;
        pending_flush_d = pending_flush_q;
        stall_count_d   = stall_count_q;
        if (pipe_stall_i) begin
            pending_flush_d = pending_flush_q | flush_i;
        end else begin
            for (int s = 1; s <= NUM_FWD_STAGES; s++) begin
                stg_valid_d[s] = stg_valid_q[s-1];
                stg_rd_d[s]    = stg_rd_q[s-1];
                stg_rw_d[s]    = stg_rw_q[s-1];
                stg_mr_d[s]    = stg_mr_q[s-1];
            end
            if (!issue_valid_i || flush_i || pending_flush_q || load_use_stall_s) begin
                stg_valid_d[0] = 1'b0;
                stg_rd_d[0]    = 5'd0;
                stg_rw_d[0]    = 1'b0;
                stg_mr_d[0]    = 1'b0;
            end else begin
                stg_valid_d[0] = 1'b1;
                stg_rd_d[0]    = issue_rd_i;
                stg_rw_d[0]    = issue_reg_write_i;
                stg_mr_d[0]    = issue_mem_read_i;
            end
            pending_flush_d = 1'b0;
            if (load_use_stall_s && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_d = stall_count_q + 32'd1;
            end else begin
                stall_count_d = stall_count_q;
            end
        end
    end

    // State registers with synchronous reset that discards all in-flight tags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stg_valid_q     <= '0;
            stg_rd_q        <= '0;
            stg_rw_q        <= '0;
            stg_mr_q        <= '0;
            pending_flush_q <= 1'b0;
            stall_count_q   <= 32'd0;
        end else begin
            stg_valid_q     <= stg_valid_d;
            stg_rd_q        <= stg_rd_d;
            stg_rw_q        <= stg_rw_d;
            stg_mr_q        <= stg_mr_d;
            pending_flush_q <= pending_flush_d;
            stall_count_q   <= stall_count_d;
        end
    end

    assign fwd_sel_o        = fwd_sel_s;
    assign load_use_stall_o = load_use_stall_s;
    assign stall_count_o    = stall_count_q;

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core. Unlike a purely combinational forwarding comparator, it owns a destination-tag pipeline (rd, reg_write, mem_read per stage) that advances in lockstep with the datapath. From that pipeline it produces per-port forward selects for EX-stage sources and a load-use stall for the ID stage. It also provides sticky flush handling across memory stalls and a stall-cycle performance counter. It sits beside the ID/EX control logic.

Parameters:
NUM_PORTS, 3, number of source read ports checked (rs1, rs2, ecall x17)
NUM_FWD_STAGES, 2, tag stages after EX that can forward (1=EX/MEM, 2=MEM/WB)
LOAD_FWD_STAGE, 2, first stage index whose load data can be forwarded
SEL_W, clog2(NUM_FWD_STAGES+1), localparam: forward-select width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  instruction leaving ID into EX this cycle
issue_rd  in  5  its destination register
issue_reg_write  in  1  it writes the register file
issue_mem_read  in  1  it is a load
pipe_stall  in  1  whole pipeline frozen (memory busy)
flush  in  1  kill instruction entering EX (mispredict)
id_src  in  NUM_PORTS*5  source registers of the instruction in ID
id_src_used  in  NUM_PORTS  per-port source valid, ID
ex_src  in  NUM_PORTS*5  source registers of the instruction in EX
ex_src_used  in  NUM_PORTS  per-port source valid, EX
fwd_sel  out  NUM_PORTS*SEL_W  per port: 0=regfile, s=forward from stage s
load_use_stall  out  1  hold IF/ID, insert bubble into EX
stall_count  out  32  saturating count of load-use stall cycles

Behaviour:
- Tag stages 0..NUM_FWD_STAGES. Stage 0 = instruction in EX; stage s = s stages later. Each stage holds {valid, rd, reg_write, mem_read}.
- A stage "produces r" when: valid && reg_write && rd==r && r!=0. x0 never matches.
- fwd_sel[p] (combinational): 0 if !ex_src_used[p]. Otherwise the smallest s in 1..NUM_FWD_STAGES producing ex_src[p]; else 0. The nearest stage always wins.
- A load in stage s < LOAD_FWD_STAGE that matches is a load-use hazard. This cannot happen in legal operation. fwd_sel still reports s; verification flags it as an assertion.
- load_use_stall (combinational): 1 if there exist p and s with id_src_used[p] and stage s producing id_src[p] with mem_read, where s+1 < LOAD_FWD_STAGE. Defaults: load in EX, consumer in ID → stall exactly 1 cycle.
- Sequential update, priority order:
  1. reset: all stage valid=0, pending_flush=0, stall_count=0.
  2. pipe_stall: all stages hold. If flush=1, set pending_flush=1. stall_count holds.
  3. Otherwise: stage[s] <= stage[s-1] for s>=1. stage[0] <= bubble (valid=0) if !issue_valid, flush, pending_flush, or load_use_stall; else {1, issue_rd, issue_reg_write, issue_mem_read}. pending_flush <= 0.
- stall_count increments on cycles with load_use_stall && !pipe_stall && !reset. It saturates at 32'hFFFF_FFFF.
- The last stage (NUM_FWD_STAGES) writes the register file in the same cycle. No tracking exists beyond it.
- Reset values: fwd_sel=0, load_use_stall=0 (all stages invalid), stall_count=0.
- Reset mid-operation discards all in-flight tags and any pending flush.

Test Plan:
- ALU chain: issue add x5 (reg_write=1). Next cycle ex_src port0=5, used=1 → fwd_sel[0]=1. Following cycle (no new writer) → fwd_sel[0]=2. Then → 0.
- Load-use: issue lw x6 (mem_read=1). Next cycle id_src port1=6 used → load_use_stall=1 for one cycle, stage0 takes bubble, stall_count=1. Next cycle ex_src port1=6 → fwd_sel[1]=2, load_use_stall=0.
- Priority/x0: stages 1 and 2 both rd=7 reg_write → fwd_sel=1 for src 7. Stage 1 rd=0 reg_write → fwd_sel=0. Port2 id/ex_src=17 with ecall_used=1 matches a writer of x17 in stage 1 → fwd_sel[2]=1.
- Memory stall: lw x8 in stage0, id_src=8, pipe_stall=1 for 3 cycles → stages frozen, load_use_stall=1 throughout, stall_count unchanged. After release → one counted stall, then forward from stage 2.
- Sticky flush: flush=1 during pipe_stall, then pipe_stall=0 with issue_valid=1, rd=9 → stage0 becomes bubble, pending_flush cleared. A subsequent issue of rd=9 is captured normally.
- Reset mid-operation: tags valid in all stages, reset=1 one cycle → all fwd_sel=0, load_use_stall=0, stall_count=0 on the next cycle.
